// File: rtl/vga_pkg.sv
// Shared VGA types and constants for the draw-stage chain.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  typedef logic [11:0] rgb_t;

  localparam rgb_t TRANSP_RGB_DEFAULT = 12'hF0F;

  // Timing fields carried down the pipeline alongside rgb
  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
  } vtiming_t;

  // Sprite placement request / committed placement
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        en;
  } spr_pos_t;
endpackage

// File: rtl/vga_if.sv
// VGA stream: timing counters, sync/blank flags and pixel colour.
interface vga_if;
  import vga_pkg::*;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  rgb_t        rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_sprite_pos.sv
// Double-buffered sprite position: shadow loads on every strobe, active
// copies shadow only on the rising edge of vertical blanking.
module draw_sprite_pos
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  spr_pos_t req,
  input  logic     pos_valid,
  input  logic     vblnk,
  output spr_pos_t act
);
  spr_pos_t shadow;
  logic     vblnk_q;

  // Shadow capture, vblnk edge detect and commit; a strobe on the edge
  // cycle bypasses the shadow so it lands in active the same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      act     <= '0;
      vblnk_q <= 1'b0;
    end else begin
      if (pos_valid)
        shadow <= req;
      if (vblnk && !vblnk_q)
        act <= pos_valid ? req : shadow;
      vblnk_q <= vblnk;
    end
  end
endmodule

// File: rtl/draw_sprite.sv
// Two-stage sprite overlay: stage 1 computes hit and ROM address from the
// incoming position, stage 2 muxes the ROM pixel over the background.
module draw_sprite
  import vga_pkg::*;
#(
  parameter int   SPR_W      = 16,
  parameter int   SPR_H      = 8,
  parameter int   SCALE_LOG2 = 1,
  parameter rgb_t TRANSP_RGB = TRANSP_RGB_DEFAULT,
  localparam int  ADDR_W     = $clog2(SPR_W*SPR_H)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  input  logic              sprite_en,
  input  logic              pos_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  vga_if.in                 vga_in,
  vga_if.out                vga_out
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam logic [11:0] W_SCR = 12'(SPR_W << SCALE_LOG2);
  localparam logic [11:0] H_SCR = 12'(SPR_H << SCALE_LOG2);

  spr_pos_t req, act;
  assign req = '{x: xpos, y: ypos, en: sprite_en};

  draw_sprite_pos u_pos (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .pos_valid (pos_valid),
    .vblnk     (vga_in.vblnk),
    .act       (act)
  );

  // 12-bit differences: bit 11 set means the beam is left of / above the
  // sprite. Positions past the visible area simply never meet ~hblnk.
  logic [11:0]       dx, dy;
  logic              hit;
  logic [ADDR_W-1:0] addr_nxt, addr_q;

  assign dx = {1'b0, vga_in.hcount} - {1'b0, act.x};
  assign dy = {1'b0, vga_in.vcount} - {1'b0, act.y};
  assign hit = ~rst & act.en & ~vga_in.hblnk & ~vga_in.vblnk &
               ~dx[11] & ~dy[11] & (dx < W_SCR) & (dy < H_SCR);

  // Power-of-two sprite: row-major address is just {row, col}.
  assign addr_nxt = {dy[SCALE_LOG2 +: YW], dx[SCALE_LOG2 +: XW]};

  // The address is presented in the same cycle as the stage-1 register
  // load so the synchronous ROM's output lines up with stage 2; addr_q
  // holds the last hit address while off-sprite.
  assign rom_addr = hit ? addr_nxt : addr_q;

  vtiming_t t1;
  rgb_t     rgb1;
  logic     hit1;

  // Stage 1: register timing, background colour, hit flag and address
  always_ff @(posedge clk) begin
    if (rst) begin
      t1     <= '0;
      rgb1   <= '0;
      hit1   <= 1'b0;
      addr_q <= '0;
    end else begin
      t1     <= '{vcount: vga_in.vcount, hcount: vga_in.hcount,
                  vsync: vga_in.vsync, hsync: vga_in.hsync,
                  vblnk: vga_in.vblnk, hblnk: vga_in.hblnk};
      rgb1   <= vga_in.rgb;
      hit1   <= hit;
      addr_q <= rom_addr;
    end
  end

  // Stage 2: overlay opaque ROM pixels, forward timing
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.hcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= t1.vcount;
      vga_out.hcount <= t1.hcount;
      vga_out.vsync  <= t1.vsync;
      vga_out.hsync  <= t1.hsync;
      vga_out.vblnk  <= t1.vblnk;
      vga_out.hblnk  <= t1.hblnk;
      vga_out.rgb    <= (hit1 && rom_data != TRANSP_RGB) ? rom_data : rgb1;
    end
  end
endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: compact timing generator (each line visits
// hcount 0..111 then 992..1055), sync ROM model, frame-level reference.
module tb_draw_sprite;
  import vga_pkg::*;

  localparam int SPR_W = 16, SPR_H = 8, SCALE_LOG2 = 1, ADDR_W = 7;
  localparam int SCL = 1 << SCALE_LOG2;
  localparam int SW = SPR_W * SCL, SH = SPR_H * SCL;
  localparam int LINE_LEN = 176, FRAME_LINES = 76, V_ACT = 72;
  localparam logic [11:0] TR = 12'hF0F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [10:0]       xpos = '0, ypos = '0;
  logic              sprite_en = 1'b0, pos_valid = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data = '0;
  logic [11:0]       rom [SPR_W*SPR_H];

  vga_if vin ();
  vga_if vout ();

  draw_sprite #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(SCALE_LOG2),
                .TRANSP_RGB(TR)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .sprite_en(sprite_en),
    .pos_valid(pos_valid), .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_in(vin), .vga_out(vout));

  always #5 clk = ~clk;

  // Synchronous ROM, one clock latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [10:0] h, v;
    logic        vs, hs, vb, hb;
    logic [11:0] rgb;
    int          frame;
    bit          in_rst;
  } exp_t;

  exp_t st1, out_e;
  int   m_sx = 0, m_sy = 0, m_ax = 0, m_ay = 0;
  bit   m_sen = 0, m_aen = 0, m_pvb = 0;
  int   rst_age = 99;
  int   n_cmp = 0, n_bad = 0;
  int   li = 0, vv = 0, frame = 0, cyc = 0;
  int   rx, ry;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (frame %0d h %0d v %0d)",
               tag, got, want, out_e.frame, out_e.h, out_e.v);
    end
  endtask

  function automatic int hc_of(input int l);
    return (l < 112) ? l : 992 + l - 112;
  endfunction

  task automatic drive_timing();
    int hc;
    hc = hc_of(li);
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vv);
    vin.hblnk  = (hc >= 1024);
    vin.hsync  = (hc >= 1030 && hc <= 1040);
    vin.vblnk  = (vv >= V_ACT);
    vin.vsync  = (vv == 73 || vv == 74);
    vin.rgb    = (frame == 1 || frame == 2) ? 12'h123 : 12'($urandom);
  endtask

  // Pixel the screen should show for the current input, from the
  // committed rectangle and magnified ROM lookup.
  function automatic exp_t ref_pix();
    exp_t e;
    int hc, vc;
    bit on;
    logic [11:0] p;
    hc = int'(vin.hcount);
    vc = int'(vin.vcount);
    e.h = vin.hcount; e.v = vin.vcount;
    e.vs = vin.vsync; e.hs = vin.hsync; e.vb = vin.vblnk; e.hb = vin.hblnk;
    e.frame = frame; e.in_rst = 0;
    on = m_aen && !vin.hblnk && !vin.vblnk &&
         hc >= m_ax && hc < m_ax + SW && vc >= m_ay && vc < m_ay + SH;
    p = on ? rom[((vc - m_ay) / SCL) * SPR_W + (hc - m_ax) / SCL] : 12'h000;
    e.rgb = (on && p != TR) ? p : vin.rgb;
    return e;
  endfunction

  task automatic model_step();
    if (rst) begin
      out_e = '{default: 0};
      out_e.in_rst = 1;
      st1 = out_e;
      m_sx = 0; m_sy = 0; m_sen = 0;
      m_ax = 0; m_ay = 0; m_aen = 0;
      m_pvb = 0;
      rst_age = 0;
    end else begin
      out_e = st1;
      st1 = ref_pix();
      if (pos_valid) begin
        m_sx = int'(xpos); m_sy = int'(ypos); m_sen = sprite_en;
      end
      if (vin.vblnk && !m_pvb) begin
        m_ax = m_sx; m_ay = m_sy; m_aen = m_sen;
      end
      m_pvb = vin.vblnk;
      rst_age++;
    end
  endtask

  task automatic set_pos(input int x, input int y, input bit en);
    xpos = 11'(x); ypos = 11'(y); sprite_en = en; pos_valid = 1'b1;
  endtask

  task automatic stim();
    pos_valid = 1'b0;
    rst = (cyc < 3);
    if (frame == 0 && vv == 30 && li == 0) set_pos(100, 50, 1);
    if (frame == 1 && vv == 60 && li == 10) set_pos(5, 5, 1);
    if (frame == 1 && vv == 60 && li == 20) set_pos(1010, 20, 1);
    if (frame == 2 && vv == V_ACT && li == 0) set_pos(rx, ry, 1);
    if (frame == 3 && vv == 40 && li == 60) rst = 1'b1;
    if (frame == 3 && vv == 50 && li == 5)
      set_pos(int'($urandom_range(0, 100)), int'($urandom_range(0, 60)), 1);
    if (frame == 4 && vv % 10 == 3 && li == 7)
      set_pos(($urandom % 2) ? int'($urandom_range(0, 111)) : int'($urandom_range(980, 1050)),
              int'($urandom_range(0, 80)), (vv == 63) ? 1'b1 : 1'($urandom));
  endtask

  task automatic compare();
    chk("timing", 32'({vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk}),
                  32'({out_e.v, out_e.h, out_e.vs, out_e.hs, out_e.vb, out_e.hb}));
    chk("rgb", 32'(vout.rgb), 32'(out_e.rgb));
    if (rst_age == 0) chk("rst_addr", 32'(rom_addr), 32'd0);
    if (rst_age <= 1) chk("rst_rgb0", 32'(vout.rgb), 32'd0);
    if (!out_e.in_rst) begin
      if (out_e.frame == 1 && out_e.h == 100 && out_e.v == 50) chk("transp_a", 32'(vout.rgb), 32'h123);
      if (out_e.frame == 1 && out_e.h == 101 && out_e.v == 51) chk("transp_b", 32'(vout.rgb), 32'h123);
      if (out_e.frame == 1 && out_e.h == 102 && out_e.v == 50) chk("rom_px1", 32'(vout.rgb), 32'(rom[1]));
      if (out_e.frame == 1 && out_e.h == 131 && out_e.v == 65) chk("rom_corner", 32'(vout.rgb), 32'(rom[127]));
      if (out_e.frame == 1 && out_e.h == 132 && out_e.v == 50) chk("right_out", 32'(vout.rgb), 32'h123);
      if (out_e.frame == 2 && out_e.h == 1012 && out_e.v == 20) chk("clip_in", 32'(vout.rgb), 32'(rom[1]));
      if (out_e.frame == 2 && out_e.h == 1023 && out_e.v == 20) chk("clip_edge", 32'(vout.rgb), 32'(rom[6]));
      if (out_e.frame == 2 && (out_e.h == 5 || out_e.h == 17) && out_e.v == 21)
        chk("no_wrap", 32'(vout.rgb), 32'h123);
      if (out_e.frame == 3 && int'(out_e.h) == rx + 2 && int'(out_e.v) == ry)
        chk("edge_commit", 32'(vout.rgb), 32'(rom[1]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    li++;
    if (li == LINE_LEN) begin
      li = 0;
      vv++;
      if (vv == FRAME_LINES) begin
        vv = 0;
        frame++;
      end
    end
    cyc++;
    drive_timing();
    stim();
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [11:0] v;
    for (int i = 0; i < SPR_W*SPR_H; i++) begin
      v = 12'($urandom);
      if (v == TR) v = 12'h0F0;
      if (i > 7 && i != 127 && $urandom % 6 == 0) v = TR;
      rom[i] = v;
    end
    rom[0] = TR;
    rx = int'($urandom_range(0, 79));
    ry = int'($urandom_range(20, 35));
    drive_timing();
    while (frame < 6 && cyc < 95000) tick();
    if (frame < 6) chk("run_bound", 32'(frame), 32'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
